// File: rtl/mux_sel_arbiter.sv
// Two-input valid/ready arbiter feeding a registered 2:1 mux beat with its steering sel.
// Optional grant counters are compiled in when MUX_ARB_STATS_EN is defined.
module mux_sel_arbiter #(
    parameter int DW     = 8,
    parameter int USE_RR = 1,
    parameter int CNT_W  = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          a_valid,
    input  logic [DW-1:0] a_data,
    output logic          a_ready,
    input  logic          b_valid,
    input  logic [DW-1:0] b_data,
    output logic          b_ready,
    output logic          out_valid,
    output logic [DW-1:0] out_data,
    input  logic          out_ready,
    output logic          sel
`ifdef MUX_ARB_STATS_EN
    ,
    output logic [CNT_W-1:0] a_cnt,
    output logic [CNT_W-1:0] b_cnt
`endif
);

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic          load;
    logic          grant_b;
    logic [DW-1:0] out_data_q, out_data_d;
    logic          sel_q, sel_d;

    // Gating with rst keeps both readies low while reset is held.
    assign load = ~rst & ((state_q == ST_EMPTY) | out_ready) & (a_valid | b_valid);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_EMPTY: if (load) state_d = ST_FULL;
            ST_FULL:  if (out_ready && !load) state_d = ST_EMPTY;
            default:  state_d = ST_EMPTY;
        endcase
    end

    always_comb begin
        out_valid = (state_q == ST_FULL);
        a_ready   = load & ~grant_b;
        b_ready   = load & grant_b;
    end

    generate
        if (USE_RR != 0) begin : g_rr
            logic last_sel_q, last_sel_d;

            always_comb begin
                last_sel_d = load ? grant_b : last_sel_q;
            end

            // Resetting to B makes A the winner of the first contested cycle.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    last_sel_q <= 1'b1;
                end else begin
                    last_sel_q <= last_sel_d;
                end
            end

            assign grant_b = b_valid & (~a_valid | ~last_sel_q);
        end else begin : g_fixed
            assign grant_b = b_valid & ~a_valid;
        end
    endgenerate

    always_comb begin
        out_data_d = out_data_q;
        sel_d      = sel_q;
        if (load) begin
            out_data_d = grant_b ? b_data : a_data;
            sel_d      = grant_b;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_data_q <= '0;
            sel_q      <= 1'b0;
        end else begin
            out_data_q <= out_data_d;
            sel_q      <= sel_d;
        end
    end

    assign out_data = out_data_q;
    assign sel      = sel_q;

`ifdef MUX_ARB_STATS_EN
    logic [CNT_W-1:0] a_cnt_q, a_cnt_d;
    logic [CNT_W-1:0] b_cnt_q, b_cnt_d;

    // Counters saturate at all-ones instead of wrapping.
    always_comb begin
        a_cnt_d = a_cnt_q;
        b_cnt_d = b_cnt_q;
        if (a_ready && (a_cnt_q != '1)) a_cnt_d = a_cnt_q + 1'b1;
        if (b_ready && (b_cnt_q != '1)) b_cnt_d = b_cnt_q + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_cnt_q <= '0;
            b_cnt_q <= '0;
        end else begin
            a_cnt_q <= a_cnt_d;
            b_cnt_q <= b_cnt_d;
        end
    end

    assign a_cnt = a_cnt_q;
    assign b_cnt = b_cnt_q;
`else
    // CNT_W only sizes the optional counters; nothing to build here.
    generate
        if (CNT_W < 1) begin : g_cnt_w_unused
        end
    endgenerate
`endif

endmodule

// File: tb/tb_mux_sel_arbiter.sv
// Directed bench for mux_sel_arbiter: a round-robin and a fixed-priority instance share stimulus.
// Counter checks are compiled in when MUX_ARB_STATS_EN is defined.
module tb_mux_sel_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       a_valid, b_valid, out_ready;
    logic [7:0] a_data, b_data;

    logic       ra_ready, rb_ready, r_out_valid, r_sel;
    logic [7:0] r_out_data;
    logic       fa_ready, fb_ready, f_out_valid, f_sel;
    logic [7:0] f_out_data;
`ifdef MUX_ARB_STATS_EN
    logic [1:0] r_a_cnt, r_b_cnt, f_a_cnt, f_b_cnt;
`endif

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    mux_sel_arbiter #(.DW(8), .USE_RR(1), .CNT_W(2)) dut_rr (
        .clk(clk), .rst(rst),
        .a_valid(a_valid), .a_data(a_data), .a_ready(ra_ready),
        .b_valid(b_valid), .b_data(b_data), .b_ready(rb_ready),
        .out_valid(r_out_valid), .out_data(r_out_data), .out_ready(out_ready),
        .sel(r_sel)
`ifdef MUX_ARB_STATS_EN
        , .a_cnt(r_a_cnt), .b_cnt(r_b_cnt)
`endif
    );

    mux_sel_arbiter #(.DW(8), .USE_RR(0), .CNT_W(2)) dut_fp (
        .clk(clk), .rst(rst),
        .a_valid(a_valid), .a_data(a_data), .a_ready(fa_ready),
        .b_valid(b_valid), .b_data(b_data), .b_ready(fb_ready),
        .out_valid(f_out_valid), .out_data(f_out_data), .out_ready(out_ready),
        .sel(f_sel)
`ifdef MUX_ARB_STATS_EN
        , .a_cnt(f_a_cnt), .b_cnt(f_b_cnt)
`endif
    );

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        a_valid = 1'b1; a_data = 8'h5A; b_valid = 1'b1; b_data = 8'hA5; out_ready = 1'b1;
        #2;
        tests_run++;
        if ({ra_ready, rb_ready, fa_ready, fb_ready} !== 4'b0000) begin
            tests_failed++;
            $display("FAIL reset_readies: got %b want 0000", {ra_ready, rb_ready, fa_ready, fb_ready});
        end
        tests_run++;
        if ({r_out_valid, r_out_data, r_sel, f_out_valid, f_out_data, f_sel} !== 20'h0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got rr v=%b d=%h s=%b fp v=%b d=%h s=%b want all 0",
                     r_out_valid, r_out_data, r_sel, f_out_valid, f_out_data, f_sel);
        end
        @(posedge clk); #1;
        tests_run++;
        if ({r_out_valid, f_out_valid} !== 2'b00) begin
            tests_failed++;
            $display("FAIL reset_no_load: got %b want 00", {r_out_valid, f_out_valid});
        end
        a_valid = 1'b0; b_valid = 1'b0;
        rst = 1'b0;
    endtask

    task automatic test_single_a();
        a_valid = 1'b1; a_data = 8'h11; b_valid = 1'b0; out_ready = 1'b1;
        #1;
        tests_run++;
        if ({ra_ready, rb_ready, fa_ready, fb_ready} !== 4'b1010) begin
            tests_failed++;
            $display("FAIL single_a_ready: got %b want 1010", {ra_ready, rb_ready, fa_ready, fb_ready});
        end
        @(posedge clk); #1;
        tests_run++;
        if ({r_out_valid, r_out_data, r_sel} !== {1'b1, 8'h11, 1'b0}) begin
            tests_failed++;
            $display("FAIL single_a_out_rr: got v=%b d=%h s=%b want v=1 d=11 s=0", r_out_valid, r_out_data, r_sel);
        end
        tests_run++;
        if ({f_out_valid, f_out_data, f_sel} !== {1'b1, 8'h11, 1'b0}) begin
            tests_failed++;
            $display("FAIL single_a_out_fp: got v=%b d=%h s=%b want v=1 d=11 s=0", f_out_valid, f_out_data, f_sel);
        end
        a_valid = 1'b0;
        #1;
        tests_run++;
        if ({ra_ready, rb_ready, fa_ready, fb_ready} !== 4'b0000) begin
            tests_failed++;
            $display("FAIL idle_ready: got %b want 0000", {ra_ready, rb_ready, fa_ready, fb_ready});
        end
        @(posedge clk); #1;
        tests_run++;
        if ({r_out_valid, r_out_data, f_out_valid, f_out_data} !== {1'b0, 8'h11, 1'b0, 8'h11}) begin
            tests_failed++;
            $display("FAIL drain: got rr v=%b d=%h fp v=%b d=%h want v=0 d=11", r_out_valid, r_out_data, f_out_valid, f_out_data);
        end
    endtask

    task automatic test_contended();
        logic [7:0] exp_d;
        do_reset();
        a_valid = 1'b1; a_data = 8'hA0; b_valid = 1'b1; b_data = 8'hB0; out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            tests_run++;
            if ({ra_ready, rb_ready} !== (i[0] ? 2'b01 : 2'b10)) begin
                tests_failed++;
                $display("FAIL rr_grant[%0d]: got %b want %b", i, {ra_ready, rb_ready}, (i[0] ? 2'b01 : 2'b10));
            end
            tests_run++;
            if ({fa_ready, fb_ready} !== 2'b10) begin
                tests_failed++;
                $display("FAIL fp_grant[%0d]: got %b want 10", i, {fa_ready, fb_ready});
            end
            @(posedge clk); #1;
            exp_d = i[0] ? 8'hB0 : 8'hA0;
            tests_run++;
            if ({r_out_valid, r_out_data, r_sel} !== {1'b1, exp_d, i[0]}) begin
                tests_failed++;
                $display("FAIL rr_out[%0d]: got v=%b d=%h s=%b want v=1 d=%h s=%b", i, r_out_valid, r_out_data, r_sel, exp_d, i[0]);
            end
            tests_run++;
            if ({f_out_valid, f_out_data, f_sel} !== {1'b1, 8'hA0, 1'b0}) begin
                tests_failed++;
                $display("FAIL fp_out[%0d]: got v=%b d=%h s=%b want v=1 d=a0 s=0", i, f_out_valid, f_out_data, f_sel);
            end
        end
        a_valid = 1'b0; b_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_backpressure();
        a_valid = 1'b1; a_data = 8'h22; b_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        a_valid = 1'b0; b_valid = 1'b1; b_data = 8'h33; out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            tests_run++;
            if ({ra_ready, rb_ready, fa_ready, fb_ready} !== 4'b0000) begin
                tests_failed++;
                $display("FAIL stall_ready[%0d]: got %b want 0000", i, {ra_ready, rb_ready, fa_ready, fb_ready});
            end
            @(posedge clk); #1;
            tests_run++;
            if ({r_out_valid, r_out_data, r_sel, f_out_valid, f_out_data, f_sel} !== {1'b1, 8'h22, 1'b0, 1'b1, 8'h22, 1'b0}) begin
                tests_failed++;
                $display("FAIL stall_hold[%0d]: got rr v=%b d=%h s=%b fp v=%b d=%h s=%b want v=1 d=22 s=0",
                         i, r_out_valid, r_out_data, r_sel, f_out_valid, f_out_data, f_sel);
            end
        end
        out_ready = 1'b1;
        #1;
        tests_run++;
        if ({ra_ready, rb_ready, fa_ready, fb_ready} !== 4'b0101) begin
            tests_failed++;
            $display("FAIL passthru_ready: got %b want 0101", {ra_ready, rb_ready, fa_ready, fb_ready});
        end
        @(posedge clk); #1;
        tests_run++;
        if ({r_out_valid, r_out_data, r_sel, f_out_valid, f_out_data, f_sel} !== {1'b1, 8'h33, 1'b1, 1'b1, 8'h33, 1'b1}) begin
            tests_failed++;
            $display("FAIL passthru_out: got rr v=%b d=%h s=%b fp v=%b d=%h s=%b want v=1 d=33 s=1",
                     r_out_valid, r_out_data, r_sel, f_out_valid, f_out_data, f_sel);
        end
        b_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            tests_run++;
            if ({r_out_valid, f_out_valid} !== 2'b00) begin
                tests_failed++;
                $display("FAIL empty_ready_ignored[%0d]: got %b want 00", i, {r_out_valid, f_out_valid});
            end
        end
    endtask

    task automatic test_reset_mid();
        a_valid = 1'b1; a_data = 8'h44; b_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        a_valid = 1'b0; out_ready = 1'b0;
        tests_run++;
        if ({r_out_valid, r_out_data} !== {1'b1, 8'h44}) begin
            tests_failed++;
            $display("FAIL pre_reset_full: got v=%b d=%h want v=1 d=44", r_out_valid, r_out_data);
        end
        #2 rst = 1'b1;
        #1;
        tests_run++;
        if ({r_out_valid, r_out_data, r_sel, f_out_valid, f_out_data, f_sel} !== 20'h0) begin
            tests_failed++;
            $display("FAIL async_reset: got rr v=%b d=%h s=%b fp v=%b d=%h s=%b want all 0",
                     r_out_valid, r_out_data, r_sel, f_out_valid, f_out_data, f_sel);
        end
        a_valid = 1'b1; a_data = 8'hA0; b_valid = 1'b1; b_data = 8'hB0; out_ready = 1'b1;
        #1;
        tests_run++;
        if ({ra_ready, rb_ready, fa_ready, fb_ready} !== 4'b0000) begin
            tests_failed++;
            $display("FAIL ready_in_reset: got %b want 0000", {ra_ready, rb_ready, fa_ready, fb_ready});
        end
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        tests_run++;
        if ({ra_ready, rb_ready} !== 2'b10) begin
            tests_failed++;
            $display("FAIL post_reset_grant: got %b want 10", {ra_ready, rb_ready});
        end
        @(posedge clk); #1;
        tests_run++;
        if ({r_out_valid, r_out_data, r_sel} !== {1'b1, 8'hA0, 1'b0}) begin
            tests_failed++;
            $display("FAIL post_reset_out: got v=%b d=%h s=%b want v=1 d=a0 s=0", r_out_valid, r_out_data, r_sel);
        end
        a_valid = 1'b0; b_valid = 1'b0;
        @(posedge clk); #1;
    endtask

`ifdef MUX_ARB_STATS_EN
    task automatic test_stats();
        logic [1:0] exp_c;
        do_reset();
        tests_run++;
        if ({r_a_cnt, r_b_cnt} !== 4'b0000) begin
            tests_failed++;
            $display("FAIL cnt_reset: got a=%0d b=%0d want 0 0", r_a_cnt, r_b_cnt);
        end
        a_valid = 1'b1; a_data = 8'h55; b_valid = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            exp_c = (i < 2) ? 2'(i + 1) : 2'd3;
            tests_run++;
            if ({r_a_cnt, r_b_cnt} !== {exp_c, 2'd0}) begin
                tests_failed++;
                $display("FAIL a_cnt[%0d]: got a=%0d b=%0d want a=%0d b=0", i, r_a_cnt, r_b_cnt, exp_c);
            end
        end
        a_valid = 1'b0;
        @(posedge clk); #1;
    endtask
`endif

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish, want finish before 50000");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        a_valid = 1'b0; b_valid = 1'b0; a_data = 8'h00; b_data = 8'h00; out_ready = 1'b0;
        test_reset();
        test_single_a();
        test_contended();
        test_backpressure();
        test_reset_mid();
`ifdef MUX_ARB_STATS_EN
        test_stats();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
